// File: rtl/tpu_pkg.sv
// Shared types, default widths and arithmetic helpers for the matrix unit.
// sat_add is only referenced when TPU_MXU_SAT_EN is defined.
package tpu_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FIN} mxu_state_e;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAccW  = 16;

  // Operands arrive sign-extended to 64 bits; the sum is clamped to a signed width-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/tpu_pe.sv
// Weight-stationary processing element: held weight, activation pass-through, psum register.
// TPU_MXU_SAT_EN selects a saturating accumulate instead of two's-complement wrap.
module tpu_pe
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              w_we_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [ACC_W-1:0]  psum_i,
  output logic [DATA_W-1:0] a_o,
  output logic [ACC_W-1:0]  psum_o
);

  logic signed [DATA_W-1:0] w_q;
  logic        [DATA_W-1:0] a_q;
  logic        [ACC_W-1:0]  psum_q;
  logic        [ACC_W-1:0]  psum_d;
  logic signed [ACC_W-1:0]  a_ext;
  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  prod;

  // Weights survive reset; every job reloads them before use.
  always_ff @(posedge clk_i) begin
    if (w_we_i) begin
      w_q <= w_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q    <= '0;
      psum_q <= '0;
    end else if (en_i) begin
      a_q    <= a_i;
      psum_q <= psum_d;
    end
  end

  always_comb begin
    a_ext = ACC_W'($signed(a_i));
    w_ext = ACC_W'(w_q);
    prod  = a_ext * w_ext;
`ifdef TPU_MXU_SAT_EN
    psum_d = ACC_W'(sat_add(64'($signed(psum_i)), 64'(prod), ACC_W));
`else
    psum_d = ACC_W'($signed(psum_i) + prod);
`endif
  end

  assign a_o    = a_q;
  assign psum_o = psum_q;

endmodule

// File: rtl/tpu_mxu.sv
// N x N weight-stationary matrix unit with job sequencer and valid/ready streaming.
// Build option: TPU_MXU_SAT_EN makes every PE accumulate saturate instead of wrap.
module tpu_mxu
  import tpu_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_rows,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [N*DATA_W-1:0] w_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [N*DATA_W-1:0] a_data,
  output logic                c_valid,
  input  logic                c_ready,
  output logic [N*ACC_W-1:0]  c_data,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BeatW  = $clog2(N);
  localparam int unsigned TagLen = 2 * N - 1;

  mxu_state_e state_q, state_d;

  logic [CNT_W-1:0]   rows_left_q;
  logic [BeatW-1:0]   beat_q;
  logic [TagLen-1:0]  tag_q;
  logic               c_valid_q;
  logic [N*ACC_W-1:0] c_data_q;

  logic               adv;
  logic               w_hs;
  logic               a_hs;
  logic [N-1:0]       w_we;

  logic [DATA_W-1:0]  a_bus    [N][N+1];
  logic [ACC_W-1:0]   psum_bus [N+1][N];
  logic [ACC_W-1:0]   col_out  [N];

  // The whole pipeline freezes only while a result is waiting on the consumer.
  assign adv  = !(c_valid_q && !c_ready);
  assign w_hs = w_valid && w_ready;
  assign a_hs = a_valid && a_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_W;
      end
      LOAD_W: begin
        if (w_hs && (beat_q == BeatW'(N - 1))) begin
          state_d = (rows_left_q == '0) ? FIN : STREAM;
        end
      end
      STREAM: begin
        if (a_hs && (rows_left_q == CNT_W'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if ((tag_q == '0) && !c_valid_q) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    a_ready = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      LOAD_W:  w_ready = 1'b1;
      STREAM:  a_ready = adv && (rows_left_q != '0);
      DRAIN:   ;
      FIN:     done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // ---------------- Counters ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_left_q <= '0;
      beat_q      <= '0;
    end else begin
      if ((state_q == IDLE) && start) begin
        rows_left_q <= num_rows;
        beat_q      <= '0;
      end
      if (w_hs) begin
        beat_q <= beat_q + BeatW'(1);
      end
      if (a_hs) begin
        rows_left_q <= rows_left_q - CNT_W'(1);
      end
    end
  end

  // ---------------- Input skew: lane k delayed k ----------------
  for (genvar k = 0; k < N; k++) begin : g_skew
    logic [DATA_W-1:0] lane_in;
    // Cycles without a handshake launch a zero bubble.
    assign lane_in = a_hs ? a_data[k*DATA_W +: DATA_W] : '0;
    assign w_we[k] = w_hs && (beat_q == BeatW'(k));

    if (k == 0) begin : g_direct
      assign a_bus[k][0] = lane_in;
    end else begin : g_dly
      logic [DATA_W-1:0] sk_q [k];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < k; i++) sk_q[i] <= '0;
        end else if (adv) begin
          sk_q[0] <= lane_in;
          for (int i = 1; i < k; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign a_bus[k][0] = sk_q[k-1];
    end
  end

  // ---------------- PE array: activations flow right, psums flow down ----------------
  for (genvar j = 0; j < N; j++) begin : g_psum_top
    assign psum_bus[0][j] = '0;
  end

  for (genvar k = 0; k < N; k++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      tpu_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (adv),
        .w_we_i  (w_we[k]),
        .w_i     (w_data[j*DATA_W +: DATA_W]),
        .a_i     (a_bus[k][j]),
        .psum_i  (psum_bus[k][j]),
        .a_o     (a_bus[k][j+1]),
        .psum_o  (psum_bus[k+1][j])
      );
    end
  end

  // ---------------- Output deskew: column j delayed N-1-j ----------------
  for (genvar j = 0; j < N; j++) begin : g_deskew
    if (j == N - 1) begin : g_direct
      assign col_out[j] = psum_bus[N][j];
    end else begin : g_dly
      logic [ACC_W-1:0] dk_q [N-1-j];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < int'(N - 1 - j); i++) dk_q[i] <= '0;
        end else if (adv) begin
          dk_q[0] <= psum_bus[N][j];
          for (int i = 1; i < int'(N - 1 - j); i++) dk_q[i] <= dk_q[i-1];
        end
      end
      assign col_out[j] = dk_q[N-2-j];
    end
  end

  // Tag lines up with the deskewed row; the output register adds the final cycle of 2N.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
    end else if (adv) begin
      tag_q <= {tag_q[TagLen-2:0], a_hs};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_valid_q <= 1'b0;
      c_data_q  <= '0;
    end else if (adv) begin
      c_valid_q <= tag_q[TagLen-1];
      for (int j = 0; j < int'(N); j++) begin
        c_data_q[j*ACC_W +: ACC_W] <= col_out[j];
      end
    end
  end

  assign c_valid = c_valid_q;
  assign c_data  = c_data_q;

endmodule

// File: tb/tb_tpu_mxu.sv
// Randomised self-checking bench for tpu_mxu (N=2, DATA_W=8, ACC_W=16) against a matrix-product model.
module tb_tpu_mxu;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_rows;
  logic          w_valid, w_ready;
  logic [N*DW-1:0] w_data;
  logic          a_valid, a_ready;
  logic [N*DW-1:0] a_data;
  logic          c_valid, c_ready;
  logic [N*AW-1:0] c_data;
  logic          busy, done;

  tpu_mxu #(
    .N      (N),
    .DATA_W (DW),
    .ACC_W  (AW),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_rows (num_rows),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .c_valid  (c_valid),
    .c_ready  (c_ready),
    .c_data   (c_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] wm [N][N];
  logic signed [DW-1:0] am [64][N];
  logic [N*AW-1:0]      exp_q [$];
  int                   hs_cyc [64];
  int                   out_idx;
  bit                   lat_chk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // C[r][j] = sum_k A[r][k] * W[k][j], accumulated in k order.
  function automatic logic [N*AW-1:0] model_row(input int r);
    logic [N*AW-1:0] res;
    longint acc;
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (AW - 1)) - 1;
    lo = -(64'sd1 <<< (AW - 1));
    for (int j = 0; j < N; j++) begin
      acc = 0;
      for (int k = 0; k < N; k++) begin
        acc = acc + longint'(am[r][k]) * longint'(wm[k][j]);
`ifdef TPU_MXU_SAT_EN
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
`else
        if (acc > hi || acc < lo) acc = acc;
`endif
      end
      res[j*AW +: AW] = acc[AW-1:0];
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (!reset && c_valid && c_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("c_extra_row", 64'(exp_q.size()), 64'd1);
      end else begin
        check_eq("c_data", 64'(c_data), 64'(exp_q.pop_front()));
        if (lat_chk) check_eq("latency", 64'(cyc - hs_cyc[out_idx]), 64'(2 * N));
        out_idx++;
      end
    end
  end

  // mode 0: c_ready=1; 1: random c_ready and a_valid; 2: stall first result for 5 cycles.
  task automatic run_job(input int nrows, input int mode, input int rst_at, input bit dbl_start);
    int wb = 0;
    int ab = 0;
    int stall_left = 5;
    int dones = 0;
    int post = 0;
    bit stalled;
    exp_q.delete();
    for (int r = 0; r < nrows; r++) exp_q.push_back(model_row(r));
    out_idx = 0;
    lat_chk = (mode == 0);
    for (int it = 0; it < 400; it++) begin
      @(posedge clk);
      #1;
      start    = (it == 0) || (dbl_start && it == 2);
      num_rows = CW'(nrows);
      stalled  = 1'b0;
      case (mode)
        1: c_ready = 1'($urandom_range(0, 1));
        2: begin
          if (c_valid && stall_left > 0) begin
            c_ready = 1'b0;
            stalled = 1'b1;
            stall_left--;
          end else begin
            c_ready = 1'b1;
          end
        end
        default: c_ready = 1'b1;
      endcase
      if (rst_at >= 0 && ab == rst_at) begin
        reset   = 1'b1;
        start   = 1'b0;
        a_valid = 1'b0;
        w_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_c_valid", 64'(c_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      w_valid = (wb < N);
      for (int j = 0; j < N; j++) w_data[j*DW +: DW] = (wb < N) ? wm[wb][j] : '0;
      a_valid = (ab < nrows) && (mode != 1 || $urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) a_data[k*DW +: DW] = (ab < nrows) ? am[ab][k] : '0;
      @(negedge clk);
      if (stalled) begin
        check_eq("stall_c_data", 64'(c_data), 64'(exp_q[0]));
        check_eq("stall_a_ready", 64'(a_ready), 64'd0);
      end
      if (dbl_start && it == 2) check_eq("busy_restart", 64'(busy), 64'd1);
      if (w_valid && w_ready) wb++;
      if (a_valid && a_ready) begin
        hs_cyc[ab] = cyc;
        ab++;
      end
      if (done) dones++;
      if (dones > 0) post++;
      if (post > 4) break;
    end
    start   = 1'b0;
    w_valid = 1'b0;
    a_valid = 1'b0;
    c_ready = 1'b1;
    check_eq("done_pulses", 64'(dones), 64'd1);
    check_eq("rows_pending", 64'(exp_q.size()), 64'd0);
    check_eq("busy_after", 64'(busy), 64'd0);
  endtask

  task automatic set_w(input int w00, input int w01, input int w10, input int w11);
    wm[0][0] = DW'(w00); wm[0][1] = DW'(w01);
    wm[1][0] = DW'(w10); wm[1][1] = DW'(w11);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_rows = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; c_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_w_ready", 64'(w_ready), 64'd0);
    check_eq("rst_a_ready", 64'(a_ready), 64'd0);
    check_eq("rst_c_valid", 64'(c_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_c_data", 64'(c_data), 64'd0);

    // Identity weights, two rows, then the same job with a 5-cycle consumer stall.
    set_w(1, 0, 0, 1);
    am[0][0] = 8'sd3; am[0][1] = 8'sd4; am[1][0] = 8'sd5; am[1][1] = 8'sd6;
    run_job(2, 0, -1, 1'b0);
    run_job(2, 2, -1, 1'b0);

    // Single row, exact 2N latency, C=[4,6].
    set_w(1, 2, 3, 4);
    am[0][0] = 8'sd1; am[0][1] = 8'sd1;
    run_job(1, 0, -1, 1'b0);

    // Overflow corner: wraps to -32768 or saturates to 32767.
    set_w(-128, -128, -128, -128);
    am[0][0] = -8'sd128; am[0][1] = -8'sd128;
    run_job(1, 0, -1, 1'b0);

    // Empty job, with a second start while busy.
    run_job(0, 0, -1, 1'b1);

    // Reset with rows in flight, then a clean job.
    set_w(1, 2, 3, 4);
    for (int r = 0; r < 4; r++) begin
      am[r][0] = DW'($urandom);
      am[r][1] = DW'($urandom);
    end
    run_job(4, 0, 2, 1'b0);
    am[0][0] = 8'sd1; am[0][1] = 8'sd1;
    run_job(1, 0, -1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      set_w(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      for (int r = 0; r < 8; r++) begin
        am[r][0] = DW'($urandom);
        am[r][1] = DW'($urandom);
      end
      run_job(int'($urandom_range(1, 8)), t % 2, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
